// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - state encoding, AXI protection default and strobe-width helper
package axi_lite_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR_REQ  = 3'd1;
    localparam state_t ST_WR_RESP = 3'd2;
    localparam state_t ST_RD_REQ  = 3'd3;
    localparam state_t ST_RD_DATA = 3'd4;
    localparam state_t ST_RSP     = 3'd5;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// rtl/axi_lite_watchdog.sv - clearable, enabled up-counter that stops at LIMIT and flags it
module axi_lite_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o = (count_q == CW'(LIMIT));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI4-Lite initiator fed by a command/response stream
// Optional watchdog: AXI_LITE_CMD_MASTER_TIMEOUT_EN
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                i_cmd_valid,
    output logic                                o_cmd_ready,
    input  logic                                i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]               i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]               i_cmd_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0]   i_cmd_wstrb,
    output logic                                o_rsp_valid,
    input  logic                                i_rsp_ready,
    output logic [DATA_WIDTH-1:0]               o_rsp_rdata,
    output logic                                o_rsp_err,
    output logic                                o_m_axi_awvalid,
    input  logic                                i_m_axi_awready,
    output logic [ADDR_WIDTH-1:0]               o_m_axi_awaddr,
    output logic [2:0]                          o_m_axi_awprot,
    output logic                                o_m_axi_wvalid,
    input  logic                                i_m_axi_wready,
    output logic [DATA_WIDTH-1:0]               o_m_axi_wdata,
    output logic [strb_width(DATA_WIDTH)-1:0]   o_m_axi_wstrb,
    input  logic                                i_m_axi_bvalid,
    output logic                                o_m_axi_bready,
    output logic                                o_m_axi_arvalid,
    input  logic                                i_m_axi_arready,
    output logic [ADDR_WIDTH-1:0]               o_m_axi_araddr,
    output logic [2:0]                          o_m_axi_arprot,
    input  logic                                i_m_axi_rvalid,
    output logic                                o_m_axi_rready,
    input  logic [DATA_WIDTH-1:0]               i_m_axi_rdata
);

    localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    cmd_hs;
    logic                    bus_active;
    logic                    timeout;

    assign cmd_hs     = i_cmd_valid && cmd_ready_q;
    assign bus_active = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                        (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);

`ifdef AXI_LITE_CMD_MASTER_TIMEOUT_EN
    logic wd_tc;
    logic err_q;

    axi_lite_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (cmd_hs),
        .enable_i (bus_active),
        .tc_o     (wd_tc)
    );

    assign timeout = wd_tc && bus_active;

    // Only the timeout path sets the error; every accepted command starts clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (cmd_hs) begin
            err_q <= 1'b0;
        end
    end

    assign o_rsp_err = err_q;
`else
    assign timeout   = 1'b0;
    assign o_rsp_err = 1'b0;
`endif

    // Every output is the registered image of the next state, so nothing combinational reaches a port.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = 1'b0;
        arvalid_d   = arvalid_q;
        rready_d    = 1'b0;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_hs) begin
                    cmd_ready_d = 1'b0;
                    if (i_cmd_write) begin
                        state_d   = ST_WR_REQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = i_cmd_addr;
                        wdata_d   = i_cmd_wdata;
                        wstrb_d   = i_cmd_wstrb;
                    end else begin
                        state_d   = ST_RD_REQ;
                        arvalid_d = 1'b1;
                        araddr_d  = i_cmd_addr;
                    end
                end
            end
            ST_WR_REQ: begin
                if (i_m_axi_awready) awvalid_d = 1'b0;
                if (i_m_axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                bready_d = 1'b1;
                if (i_m_axi_bvalid) begin
                    state_d     = ST_RSP;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                end
            end
            ST_RD_REQ: begin
                if (i_m_axi_arready) begin
                    state_d   = ST_RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                rready_d = 1'b1;
                if (i_m_axi_rvalid) begin
                    state_d     = ST_RSP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = i_m_axi_rdata;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A timed-out transaction abandons the bus; a late slave response is never taken.
        if (timeout) begin
            state_d     = ST_RSP;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            bready_d    = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    assign o_cmd_ready     = cmd_ready_q;
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_rdata     = rdata_q;
    assign o_m_axi_awvalid = awvalid_q;
    assign o_m_axi_awaddr  = awaddr_q;
    assign o_m_axi_awprot  = AXI_PROT_DEFAULT;
    assign o_m_axi_wvalid  = wvalid_q;
    assign o_m_axi_wdata   = wdata_q;
    assign o_m_axi_wstrb   = wstrb_q;
    assign o_m_axi_bready  = bready_q;
    assign o_m_axi_arvalid = arvalid_q;
    assign o_m_axi_araddr  = araddr_q;
    assign o_m_axi_arprot  = AXI_PROT_DEFAULT;
    assign o_m_axi_rready  = rready_q;

endmodule
